// File: rtl/csa_reduce_pipe.sv
// Pipelined 3:2 carry-save reduction tree: NUM_OPS unsigned operands down to a sum/carry pair.
// Registers sit after every STAGE_LVLS layers and beats move under a valid/ready handshake.
module csa_reduce_pipe #(
    parameter int WIDTH      = 64,
    parameter int NUM_OPS    = 8,
    parameter int STAGE_LVLS = 2,
    parameter int TAG_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] i_in_ops,
    input  logic [TAG_W-1:0]         i_in_tag,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [WIDTH-1:0]         o_out_sum,
    output logic [WIDTH-1:0]         o_out_carry,
    output logic [TAG_W-1:0]         o_out_tag
);

    function automatic int ops_at(input int lvl);
        int n;
        n = NUM_OPS;
        for (int i = 0; i < lvl; i++) n = 2 * (n / 3) + n % 3;
        return n;
    endfunction

    function automatic int calc_levels();
        int n;
        int l;
        n = NUM_OPS;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS  = calc_levels();
    localparam int NUM_STG = (LEVELS + STAGE_LVLS - 1) / STAGE_LVLS;

    logic [NUM_STG-1:0] r_v;
    logic [NUM_STG-1:0] w_adv;
    logic [NUM_STG-1:0] w_load;
    logic [NUM_STG-1:0] w_cap;
    logic [TAG_W-1:0]   r_tag [NUM_STG];

    // Walk from the output backwards: a stage may load when the stage after it can.
    always_comb begin
        logic rdy;
        w_adv  = '0;
        w_load = '0;
        w_cap  = '0;
        rdy    = i_out_ready;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            w_adv[k]  = r_v[k] & rdy;
            w_load[k] = ~r_v[k] | w_adv[k];
            rdy       = w_load[k];
        end
        w_cap[0] = i_in_valid & w_load[0];
        for (int k = 1; k < NUM_STG; k++) w_cap[k] = w_adv[k-1];
    end

    assign o_in_ready  = w_load[0];
    assign o_out_valid = r_v[NUM_STG-1];
    assign o_out_tag   = r_tag[NUM_STG-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
        end else if (i_flush) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < NUM_STG; k++)
                if (w_load[k]) r_v[k] <= w_cap[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STG; k++) r_tag[k] <= '0;
        end else begin
            if (w_cap[0]) r_tag[0] <= i_in_tag;
            for (int k = 1; k < NUM_STG; k++)
                if (w_cap[k]) r_tag[k] <= r_tag[k-1];
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lay
        localparam int N_IN   = ops_at(l - 1);
        localparam int N_OUT  = ops_at(l);
        localparam int G      = N_IN / 3;
        localparam int R      = N_IN % 3;
        localparam int STG    = (l - 1) / STAGE_LVLS;
        localparam bit IS_END = ((l % STAGE_LVLS) == 0) || (l == LEVELS);

        logic [N_IN*WIDTH-1:0]  w_src;
        logic [N_OUT*WIDTH-1:0] w_comb;
        logic [N_OUT*WIDTH-1:0] w_out;

        if (l == 1) begin : g_src_in
            assign w_src = i_in_ops;
        end else begin : g_src_lay
            assign w_src = g_lay[l-1].w_out;
        end

        // Group g yields sum at slot 2g and carry at slot 2g+1; carry-out of the MSB is dropped.
        for (genvar g = 0; g < G; g++) begin : g_fa
            logic [WIDTH-1:0] w_a, w_b, w_c;
            assign w_a = w_src[(3*g)*WIDTH +: WIDTH];
            assign w_b = w_src[(3*g+1)*WIDTH +: WIDTH];
            assign w_c = w_src[(3*g+2)*WIDTH +: WIDTH];
            assign w_comb[(2*g)*WIDTH +: WIDTH]   = w_a ^ w_b ^ w_c;
            assign w_comb[(2*g+1)*WIDTH +: WIDTH] = ((w_a & w_b) | (w_a & w_c) | (w_b & w_c)) << 1;
        end

        if (R > 0) begin : g_pass
            assign w_comb[N_OUT*WIDTH-1 : 2*G*WIDTH] = w_src[N_IN*WIDTH-1 : 3*G*WIDTH];
        end

        if (IS_END) begin : g_reg
            logic [N_OUT*WIDTH-1:0] r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)          r_q <= '0;
                else if (w_cap[STG]) r_q <= w_comb;
            end
            assign w_out = r_q;
        end else begin : g_comb
            assign w_out = w_comb;
        end
    end

    assign o_out_sum   = g_lay[LEVELS].w_out[WIDTH-1:0];
    assign o_out_carry = g_lay[LEVELS].w_out[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_csa_reduce_pipe.sv
// Directed bench for csa_reduce_pipe: three configurations (8 ops/2 stages, 3 ops/1 stage, 5 ops/3 stages).
module tb_csa_reduce_pipe;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic           a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [8*W-1:0] a_ops;
    logic [3:0]     a_in_tag, a_out_tag;
    logic [W-1:0]   a_sum, a_carry;

    logic           b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3*W-1:0] b_ops;
    logic [3:0]     b_in_tag, b_out_tag;
    logic [W-1:0]   b_sum, b_carry;

    logic           c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [5*W-1:0] c_ops;
    logic [3:0]     c_in_tag, c_out_tag;
    logic [W-1:0]   c_sum, c_carry;

    csa_reduce_pipe #(.WIDTH(W), .NUM_OPS(8), .STAGE_LVLS(2), .TAG_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .i_flush(a_flush), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
        .i_in_ops(a_ops), .i_in_tag(a_in_tag), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
        .o_out_sum(a_sum), .o_out_carry(a_carry), .o_out_tag(a_out_tag));

    csa_reduce_pipe #(.WIDTH(W), .NUM_OPS(3), .STAGE_LVLS(1), .TAG_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .i_flush(b_flush), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
        .i_in_ops(b_ops), .i_in_tag(b_in_tag), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
        .o_out_sum(b_sum), .o_out_carry(b_carry), .o_out_tag(b_out_tag));

    csa_reduce_pipe #(.WIDTH(W), .NUM_OPS(5), .STAGE_LVLS(1), .TAG_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .i_flush(c_flush), .i_in_valid(c_in_valid), .o_in_ready(c_in_ready),
        .i_in_ops(c_ops), .i_in_tag(c_in_tag), .o_out_valid(c_out_valid), .i_out_ready(c_out_ready),
        .o_out_sum(c_sum), .o_out_carry(c_carry), .o_out_tag(c_out_tag));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] beat_op(input int b, input int i);
        return W'(b * 37 + i * 11 + 3);
    endfunction

    function automatic logic [W-1:0] beat_sum(input int b);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + beat_op(b, i);
        return s;
    endfunction

    task automatic set_a_beat(input int b);
        for (int i = 0; i < 8; i++) a_ops[i*W +: W] = beat_op(b, i);
        a_in_tag = 4'(b);
    endtask

    function automatic logic [W-1:0] tot_a();
        return a_sum + a_carry;
    endfunction

    function automatic logic [W-1:0] tot_c();
        return c_sum + c_carry;
    endfunction

    initial begin
        int beat, rcv, cyc;
        logic acc, ret;

        a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_ops = '0; a_in_tag = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_ops = '0; b_in_tag = '0;
        c_flush = 0; c_in_valid = 0; c_out_ready = 1; c_ops = '0; c_in_tag = '0;

        #2;
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_sum", a_sum, 0);
        check("rst_a_carry", a_carry, 0);
        check("rst_a_tag", a_out_tag, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_valid", b_out_valid, 0);
        check("rst_c_valid", c_out_valid, 0);
        #10 rst_n = 1'b1;
        tick();

        // Basic sum: operands 1..8, latency two stages
        for (int i = 0; i < 8; i++) a_ops[i*W +: W] = W'(i + 1);
        a_in_tag = 4'd5; a_in_valid = 1;
        #2 check("basic_in_ready", a_in_ready, 1);
        tick();
        a_in_valid = 0;
        #2 check("basic_lat_t0", a_out_valid, 0);
        tick();
        #2;
        check("basic_valid", a_out_valid, 1);
        check("basic_sum", tot_a(), 36);
        check("basic_tag", a_out_tag, 5);
        tick();
        #2 check("basic_retired", a_out_valid, 0);

        // Overflow wrap on the single-stage tree
        b_ops = {8'h00, 8'h01, 8'hFF}; b_in_tag = 4'd7; b_in_valid = 1;
        tick();
        b_in_valid = 0;
        #2;
        check("wrap_b_valid", b_out_valid, 1);
        check("wrap_b_sum", b_sum, 8'hFE);
        check("wrap_b_carry", b_carry, 8'h02);
        check("wrap_b_total", 8'(b_sum + b_carry), 8'h00);
        check("wrap_b_tag", b_out_tag, 7);
        tick();
        #2 check("wrap_b_retired", b_out_valid, 0);

        a_ops = {8{8'hFF}}; a_in_tag = 4'hA; a_in_valid = 1;
        tick();
        a_in_valid = 0;
        tick();
        #2;
        check("wrap_a_valid", a_out_valid, 1);
        check("wrap_a_total", tot_a(), 8'hF8);
        check("wrap_a_tag", a_out_tag, 4'hA);
        tick();

        // Three-stage tree: latency 3, then back-to-back throughput
        for (int i = 0; i < 5; i++) c_ops[i*W +: W] = W'(10 * (i + 1));
        c_in_tag = 4'd3; c_in_valid = 1;
        tick();
        c_in_valid = 0;
        #2 check("c_lat_1", c_out_valid, 0);
        tick();
        #2 check("c_lat_2", c_out_valid, 0);
        tick();
        #2;
        check("c_valid", c_out_valid, 1);
        check("c_sum", tot_c(), 150);
        check("c_tag", c_out_tag, 3);
        tick();
        for (int k = 0; k < 7; k++) begin
            if (k < 3) begin
                c_in_valid = 1;
                c_in_tag = 4'(k);
                for (int i = 0; i < 5; i++) c_ops[i*W +: W] = W'(k + 1);
            end else begin
                c_in_valid = 0;
            end
            #2;
            if (k < 3) check("c_tp_in_ready", c_in_ready, 1);
            if (k >= 3 && k < 6) begin
                check("c_tp_valid", c_out_valid, 1);
                check("c_tp_tag", c_out_tag, 32'(k - 3));
                check("c_tp_sum", tot_c(), 32'(5 * (k - 2)));
            end
            if (k == 6) check("c_tp_drained", c_out_valid, 0);
            tick();
        end

        // Back-pressure: 6 beats, out_ready low for the first 6 cycles
        beat = 0; rcv = 0; cyc = 0;
        while (rcv < 6 && cyc < 40) begin
            a_out_ready = (cyc >= 6);
            if (beat < 6) begin
                a_in_valid = 1;
                set_a_beat(beat);
            end else begin
                a_in_valid = 0;
            end
            #2;
            if (cyc == 2) check("bp_accepted", beat, 2);
            if (cyc >= 2 && cyc <= 5) begin
                check("bp_in_ready", a_in_ready, 0);
                check("bp_stall_valid", a_out_valid, 1);
                check("bp_stall_tag", a_out_tag, 0);
                check("bp_stall_sum", tot_a(), beat_sum(0));
            end
            acc = a_in_valid & a_in_ready;
            ret = a_out_valid & a_out_ready;
            if (ret) begin
                check("bp_tag", a_out_tag, 32'(rcv));
                check("bp_sum", tot_a(), beat_sum(rcv));
                rcv++;
            end
            if (acc) beat++;
            tick();
            cyc++;
        end
        check("bp_count", rcv, 6);
        a_in_valid = 0;
        #2 check("bp_no_dup", a_out_valid, 0);
        tick();

        // Flush with a beat offered in the same cycle
        a_out_ready = 0;
        a_in_valid = 1; set_a_beat(8);
        tick();
        set_a_beat(9);
        tick();
        set_a_beat(14); a_flush = 1;
        #2;
        check("fl_pre_valid", a_out_valid, 1);
        check("fl_pre_tag", a_out_tag, 8);
        tick();
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        #2;
        check("fl_cleared", a_out_valid, 0);
        check("fl_in_ready", a_in_ready, 1);
        repeat (3) begin
            tick();
            #2 check("fl_no_stale", a_out_valid, 0);
        end
        tick();
        a_in_valid = 1; set_a_beat(3);
        tick();
        a_in_valid = 0;
        #2 check("fl_after_lat", a_out_valid, 0);
        tick();
        #2;
        check("fl_after_valid", a_out_valid, 1);
        check("fl_after_tag", a_out_tag, 3);
        check("fl_after_sum", tot_a(), beat_sum(3));
        tick();

        // Asynchronous reset between edges with the pipeline full
        a_out_ready = 0;
        a_in_valid = 1; set_a_beat(1);
        tick();
        set_a_beat(2);
        tick();
        a_in_valid = 0;
        #2 check("mr_full_tag", a_out_tag, 1);
        rst_n = 1'b0;
        #1;
        check("mr_valid", a_out_valid, 0);
        check("mr_sum", a_sum, 0);
        check("mr_carry", a_carry, 0);
        check("mr_tag", a_out_tag, 0);
        check("mr_in_ready", a_in_ready, 1);
        #3 rst_n = 1'b1;
        a_out_ready = 1;
        repeat (3) begin
            tick();
            #2 check("mr_no_stale", a_out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/csa_reduce_pipe.md
# csa_reduce_pipe

Parametrised, pipelined carry-save reduction tree for the multiplier datapath in the EXU. It reduces NUM_OPS operands of WIDTH bits to one redundant sum/carry pair using layers of full-adder (3:2) compression. Pipeline registers are inserted every STAGE_LVLS layers, and data flows under a valid/ready handshake with back-pressure and flush. The final carry-propagate adder is outside this block.

## Interface
- WIDTH, 64: operand and result width in bits (≥2).
- NUM_OPS, 8: number of operands (≥3).
- STAGE_LVLS, 2: CSA layers per pipeline stage (≥1).
- TAG_W, 4: sideband tag width (≥1); the tag travels alongside its data unchanged.
- clk  in  1  clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all in-flight entries.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_ops  in  NUM_OPS*WIDTH  operand i is bits [i*WIDTH +: WIDTH].
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  redundant sum vector.
- out_carry  out  WIDTH  redundant carry vector, already shifted left by 1.
- out_tag  out  TAG_W  tag of the result beat.

## Operation
- Layer reduction: with n operands at a layer, group them in threes from index 0.
  - Each group of three becomes s = a^b^c and c = ((a&b)|(a&c)|(b&c)) << 1, truncated to WIDTH.
  - The n mod 3 leftover operands pass through unchanged.
  - The next layer has n' = 2*floor(n/3) + (n mod 3) operands. Repeat until n = 2.
- LEVELS is the number of layers. Examples: NUM_OPS=3 gives 1; 4 gives 2; 8 gives 4 (8→6→4→3→2).
- NUM_STG = ceil(LEVELS/STAGE_LVLS).
  - Stage k registers the output of layer min((k+1)*STAGE_LVLS, LEVELS).
  - Stage 0 is fed combinationally from in_ops.
- Arithmetic rule: out_sum + out_carry ≡ Σ in_ops (mod 2^WIDTH). Bits carried out of the MSB are discarded at every layer. Operands are treated as unsigned; sign extension is the caller's job.
- Each stage k holds v[k], data and tag.
  - adv[k] = v[k] & (k==NUM_STG-1 ? out_ready : !v[k+1] | adv[k+1]).
  - load[k] = !v[k] | adv[k].
  - in_ready = load[0]; this is a combinational path from out_ready.
  - Stage 0 captures input when in_valid & in_ready. Stage k>0 captures from stage k-1 when adv[k-1].
  - v[k] next value when loading: stage 0 gets in_valid; stage k>0 gets adv[k-1]. Otherwise v[k] holds.
  - A stage whose v[k]=1 and !load[k] holds its data and tag stable.
- out_valid = v[NUM_STG-1]. out_sum, out_carry and out_tag are that stage's registers.
- Flush: all v[k] go to 0 at the next edge. Flush takes priority over a same-cycle in_valid; that beat is dropped, although in_ready may still read 1. Data registers need not be cleared.
- Reset (rst_n=0), asynchronous at any time, including mid-stream:
  - all v[k]=0; all data and tag registers are 0;
  - so out_valid=0, out_sum=0, out_carry=0, out_tag=0, and in_ready=1.
  - Every in-flight beat is lost.

## Timing
- Latency: a beat accepted at edge T appears with out_valid=1 after edge T+NUM_STG-1, i.e. it is visible in cycle T+NUM_STG when there is no stall. Defaults (8 ops, 2 layers/stage) give NUM_STG=2.
- Throughput: one beat per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, the outputs stay bit-stable. Bubbles upstream compress until all NUM_STG stages are full; then in_ready=0.
- A full pipeline with out_ready=1 accepts a new beat in the same cycle one retires (pass-through, no bubble).
- No combinational path exists from in_valid/in_ops to any output.

## Test plan
- Basic sum: WIDTH=8, NUM_OPS=8, operands 1..8, tag 5, out_ready=1 → out_valid two cycles after acceptance, (out_sum+out_carry) mod 256 = 36, out_tag=5.
- Overflow wrap: WIDTH=8, NUM_OPS=3, operands 0xFF,0x01,0x00 → NUM_STG=1, out_sum=0xFE, out_carry=0x02, sum+carry mod 256 = 0x00. Also eight operands of 0xFF → (sum+carry) mod 256 = 0xF8.
- Back-pressure: stream 6 beats with random operands and hold out_ready=0.
  - in_ready drops after NUM_STG beats and the outputs stay stable.
  - Release out_ready: all 6 results emerge in order with correct sums and no duplicates or losses.
- Flush: load 2 beats, then assert flush together with in_valid=1.
  - Next cycle out_valid=0 and no stage is valid.
  - The beat offered during flush never appears.
  - A following beat returns with normal latency.
- Reset mid-operation: drop rst_n asynchronously between edges with the pipeline full → all outputs are 0 immediately, in_ready=1, and no stale beat appears after release.
- Random scoreboard: NUM_OPS ∈ {3,4,5,9}, STAGE_LVLS ∈ {1,3}, random valid/ready, 10k beats → every result matches Σ mod 2^WIDTH and the latency equals NUM_STG under no stall.
